// File: rtl/picorv32_mem_sched_if.sv
// Native memory bus between the scheduler (master) and the memory system (slave).
interface picorv32_mem_sched_if;
    logic        mem_valid;
    logic        mem_instr;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;

    modport master (output mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
                    input  mem_ready, mem_rdata);
    modport slave  (input  mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
                    output mem_ready, mem_rdata);
endinterface

// File: rtl/picorv32_mem_sched.sv
// Fetch/load-store arbiter and sequencer for the native memory bus.
// Optional: define PICORV32_MEM_SCHED_SIGNEXT_EN to add req_signed (sign-extended narrow loads).
module picorv32_mem_sched #(
    parameter bit          CATCH_MISALIGN = 1'b1,
    parameter int unsigned TIMEOUT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        req_rinst,
    input  logic [31:0] req_inst_addr,
    input  logic        req_rdata,
    input  logic        req_wdata,
    input  logic [31:0] req_data_addr,
    input  logic [1:0]  req_wordsize,
    input  logic [31:0] req_wdata_val,
`ifdef PICORV32_MEM_SCHED_SIGNEXT_EN
    input  logic        req_signed,
`endif
    output logic        done_inst,
    output logic        done_data,
    output logic [31:0] rdata_out,
    output logic        misalign,
    output logic        bus_err,
    picorv32_mem_sched_if.master mem
);
    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    localparam bit          TO_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [15:0] TO_LAST = 16'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

    state_t      state, state_nxt;
    logic        last_data, cur_data, cur_wr, flt_mis, flt_to, signed_q;
    logic [1:0]  cur_sz, cur_lo;
    logic [31:0] addr_q, wdata_q;
    logic [3:0]  wstrb_q;
    logic [15:0] to_cnt;

    logic        grant, gnt_data, gnt_mis, to_hit;
    logic [31:0] gnt_addr;
    logic [1:0]  gnt_sz;

    function automatic logic [3:0] strb_of(input logic [1:0] sz, input logic [1:0] lo);
        if (sz == 2'd0)      return 4'b1111;
        else if (sz == 2'd1) return lo[1] ? 4'b1100 : 4'b0011;
        else                 return 4'b0001 << lo;
    endfunction

    function automatic logic [31:0] rep_of(input logic [1:0] sz, input logic [31:0] wd);
        if (sz == 2'd0)      return wd;
        else if (sz == 2'd1) return {2{wd[15:0]}};
        else                 return {4{wd[7:0]}};
    endfunction

    function automatic logic [31:0] extract(input logic [31:0] d, input logic [1:0] sz,
                                            input logic [1:0] lo, input logic sgn);
        logic [15:0] h;
        logic [7:0]  b;
        h = lo[1] ? d[31:16] : d[15:0];
        b = d[{lo, 3'b000} +: 8];
        if (sz == 2'd0)      return d;
        else if (sz == 2'd1) return {{16{sgn & h[15]}}, h};
        else                 return {{24{sgn & b[7]}}, b};
    endfunction

    always_comb begin
        state_nxt = state;
        grant     = 1'b0;
        gnt_data  = 1'b0;
        gnt_addr  = req_inst_addr;
        gnt_sz    = 2'd0;
        gnt_mis   = 1'b0;
        to_hit    = 1'b0;
        case (state)
            IDLE: if (req_rinst || req_rdata || req_wdata) begin
                grant    = 1'b1;
                // Under contention the class that did not win last time goes first.
                gnt_data = (req_rdata || req_wdata) && (!req_rinst || !last_data);
                if (gnt_data) begin
                    gnt_addr = req_data_addr;
                    gnt_sz   = req_wordsize;
                end
                if (CATCH_MISALIGN)
                    gnt_mis = (gnt_sz == 2'd0) ? (gnt_addr[1:0] != 2'b00) :
                              (gnt_sz == 2'd1) ? gnt_addr[0] : 1'b0;
                state_nxt = gnt_mis ? RESP : BUSY;
            end
            BUSY: begin
                if (mem.mem_ready) begin
                    state_nxt = RESP;
                end else if (TO_EN && to_cnt == TO_LAST) begin
                    to_hit    = 1'b1;
                    state_nxt = RESP;
                end
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            last_data <= 1'b0;
            cur_data  <= 1'b0;
            cur_wr    <= 1'b0;
            cur_sz    <= 2'd0;
            cur_lo    <= 2'd0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            flt_mis   <= 1'b0;
            flt_to    <= 1'b0;
            to_cnt    <= '0;
            rdata_out <= '0;
`ifdef PICORV32_MEM_SCHED_SIGNEXT_EN
            signed_q  <= 1'b0;
`endif
        end else begin
            state <= state_nxt;
            if (grant) begin
                last_data <= gnt_data;
                cur_data  <= gnt_data;
                cur_wr    <= gnt_data && req_wdata;
                cur_sz    <= gnt_sz;
                cur_lo    <= gnt_addr[1:0];
                addr_q    <= {gnt_addr[31:2], 2'b00};
                wstrb_q   <= (gnt_data && req_wdata) ? strb_of(gnt_sz, gnt_addr[1:0]) : 4'b0000;
                wdata_q   <= rep_of(gnt_sz, req_wdata_val);
                flt_mis   <= gnt_mis;
                flt_to    <= 1'b0;
                to_cnt    <= '0;
`ifdef PICORV32_MEM_SCHED_SIGNEXT_EN
                signed_q  <= req_signed;
`endif
            end
            if (state == BUSY) begin
                if (mem.mem_ready) begin
                    if (!cur_wr) rdata_out <= extract(mem.mem_rdata, cur_sz, cur_lo, signed_q);
                end else if (to_hit) begin
                    flt_to <= 1'b1;
                end else begin
                    to_cnt <= to_cnt + 16'd1;
                end
            end
        end
    end

`ifndef PICORV32_MEM_SCHED_SIGNEXT_EN
    assign signed_q = 1'b0;
`endif

    assign mem.mem_valid = (state == BUSY);
    assign mem.mem_instr = (state == BUSY) && !cur_data;
    assign mem.mem_addr  = addr_q;
    assign mem.mem_wdata = wdata_q;
    assign mem.mem_wstrb = wstrb_q;

    assign done_inst = (state == RESP) && !flt_mis && !flt_to && !cur_data;
    assign done_data = (state == RESP) && !flt_mis && !flt_to &&  cur_data;
    assign misalign  = (state == RESP) && flt_mis;
    assign bus_err   = (state == RESP) && flt_to;
endmodule

// File: doc/picorv32_mem_sched.md
Name: picorv32_mem_sched

Overview:
Sequencer and arbiter for the core's native memory bus. Accepts level-held requests from the instruction fetch unit and the load/store unit, and grants the single bus between them with alternating priority under contention. For each granted request it generates word-aligned address, byte strobes and replicated write data, and returns right-justified read data. Detects misaligned accesses and optional bus timeouts without issuing or completing a bus cycle.

Parameters:
CATCH_MISALIGN, 1, 1 = check alignment and flag misaligned requests; 0 = no check, address low bits ignored.
TIMEOUT_CYCLES, 0, 0 = no timeout; N>0 = abort the bus cycle after N BUSY cycles without mem_ready (16-bit counter, N max 65535).

Ports:
clk  in  1  clock, rising edge
resetn  in  1  asynchronous active-low reset
req_rinst  in  1  instruction fetch request, held until done_inst or fault
req_inst_addr  in  32  fetch address
req_rdata  in  1  load request, held until done_data or fault
req_wdata  in  1  store request, held until done_data or fault (never high together with req_rdata)
req_data_addr  in  32  load/store byte address
req_wordsize  in  2  0 = word, 1 = half, 2 = byte (3 is treated as byte)
req_wdata_val  in  32  store data, right-justified
done_inst  out  1  one-cycle pulse: fetch complete, rdata_out valid
done_data  out  1  one-cycle pulse: load/store complete, rdata_out valid for loads
rdata_out  out  32  read data, lane-extracted and zero-extended
misalign  out  1  one-cycle pulse: granted request was misaligned, no bus cycle issued
bus_err  out  1  one-cycle pulse: timeout abort
mem_valid  out  1  bus request
mem_instr  out  1  high while the bus cycle is a fetch
mem_ready  in  1  bus acknowledge
mem_addr  out  32  {addr[31:2],2'b00}
mem_wdata  out  32  replicated store data
mem_wstrb  out  4  byte enables; 0 for reads
mem_rdata  in  32  bus read data

Behaviour:
- Reset, asynchronous: state = IDLE; last_grant = inst; all outputs 0; timeout counter 0. Reset during BUSY drops mem_valid immediately. No done pulse is produced for the aborted request.
- State machine:
  - IDLE: if any request is present, grant one, latch address, kind, size and data, then go to BUSY. A misaligned grant goes to RESP with the fault flag set instead.
  - BUSY: mem_valid = 1, all bus outputs stable. When mem_ready is sampled high, latch the extracted rdata and go to RESP. On timeout, go to RESP with the timeout flag set.
  - RESP: lasts exactly one cycle and raises exactly one of done_inst, done_data, misalign or bus_err. mem_valid = 0. Requests are ignored in this cycle so a still-held request is not re-issued. Next state is IDLE.
- Arbitration:
  - Only one request pending: grant it.
  - Both pending: grant the class opposite to last_grant.
  - last_grant is updated on every grant, including faulting grants.
- Latency: request sampled in IDLE at cycle N; mem_valid high from N+1. mem_ready high at cycle M gives mem_valid low and done high at M+1. Minimum request-to-done is 2 cycles. Back-to-back grants are separated by the RESP cycle plus one IDLE cycle.
- Misalignment, when CATCH_MISALIGN = 1:
  - fetch with addr[1:0] != 0;
  - word with addr[1:0] != 0;
  - half with addr[0] != 0.
- Strobes and write data:
  - word: wstrb = 1111, wdata as given.
  - half: wstrb = addr[1] ? 1100 : 0011, wdata = {2{wd[15:0]}}.
  - byte: wstrb = 0001 << addr[1:0], wdata = {4{wd[7:0]}}.
- Read extraction:
  - word: passed through unchanged.
  - half: mem_rdata[31:16] or [15:0] selected by addr[1].
  - byte: lane selected by addr[1:0].
  - All narrow results are zero-extended. rdata_out holds its value until the next completed read.
- A requester dropping its request while BUSY does not cancel the bus cycle; the cycle completes and done still pulses.
- mem_ready is ignored outside BUSY.
- Timeout counter clears on entry to BUSY.

Optional Feature:
PICORV32_MEM_SCHED_SIGNEXT_EN:
- Defined: adds input req_signed (1 bit), latched at grant. Half and byte loads with req_signed = 1 are sign-extended into rdata_out.
- Undefined: the port is absent and all narrow loads are zero-extended.

Test Plan:
- Fetch at 0x100, mem_ready in the first BUSY cycle, mem_rdata = 0x00000013 -> mem_valid for 1 cycle, mem_instr = 1, done_inst 2 cycles after the request, rdata_out = 0x00000013.
- Store byte 0xA5 to 0x1003 -> mem_addr = 0x1000, mem_wstrb = 1000, mem_wdata = 0xA5A5A5A5, done_data pulse.
- Fetch and load asserted together from reset, then both re-asserted -> load granted first (last_grant = inst after reset), then fetch, then load (alternating).
- Load half from 0x2001 -> misalign pulse, no mem_valid, no done_data.
- TIMEOUT_CYCLES = 4 with mem_ready held low -> mem_valid high for 4 cycles, then bus_err pulse and return to IDLE. Repeat with resetn asserted mid-BUSY -> mem_valid low immediately, no done pulse.
- Load half from 0x3002 with mem_rdata = 0x80FF1234 -> rdata_out = 0x000080FF; with PICORV32_MEM_SCHED_SIGNEXT_EN defined and req_signed = 1 -> 0xFFFF80FF.
